// File: rtl/ibex_icache_fetch_pkg.sv
// Shared types for the icache core-side fetch sequencer.
package ibex_icache_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    ERR_WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
    logic        err_plus2;
    logic        compressed;
  } fetch_entry_t;

  // RVC instructions are those whose two low bits are not 2'b11.
  function automatic logic is_compressed(input logic [31:0] rdata);
    return rdata[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_icache_fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush overrides push and pop.
module ibex_icache_fetch_fifo
  import ibex_icache_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  fetch_entry_t    mem [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            push_eff, pop_eff;

  assign full     = count_q == CntW'(Depth);
  assign empty    = count_q == '0;
  assign count    = count_q;
  assign push_eff = push & ~full;
  assign pop_eff  = pop & ~empty;
  assign rdata    = mem[rptr_q];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_eff) wptr_q <= wptr_q + PtrW'(1);
      if (pop_eff)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_eff) - CntW'(pop_eff);
    end
  end

  // Entry storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk_i) begin
    if (push_eff && !flush) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/ibex_icache_fetch_seq.sv
// Core-side fetch sequencer for the icache: branches, accepts responses and
// buffers them toward decode. Optional FETCH_SEQ_PC_CHECK_EN adds an
// expected-PC tracker that flags response addresses off the fetch stream.
module ibex_icache_fetch_seq
  import ibex_icache_fetch_pkg::*;
#(
  parameter int unsigned FifoDepth = 2,
  parameter logic [31:0] ResetPc   = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        icache_en_i,
  input  logic        flush_i,
  output logic        req_o,
  output logic        branch_o,
  output logic        branch_spec_o,
  output logic [31:0] branch_addr_o,
  output logic        ready_o,
  output logic        enable_o,
  output logic        invalidate_o,
  input  logic        valid_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] addr_i,
  input  logic        err_i,
  input  logic        err_plus2_i,
  input  logic        busy_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_err_o,
  output logic        instr_err_plus2_o,
  output logic        instr_compressed_o,
  output logic        pc_mismatch_o
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  fetch_state_e    state_q, state_d;
  logic [31:0]     branch_addr_q;
  logic [31:0]     redirect_tgt;
  logic            boot_branch, redirect_branch;
  logic            accept, fifo_pop, fifo_full, fifo_empty;
  fetch_entry_t    push_entry, head;
  logic [CntW-1:0] unused_fifo_count;
  logic            unused_inputs;

  assign unused_inputs = ^{busy_i, redirect_addr_i[0]};

  // Branch generation: boot branch once req is up, or a redirect at any time.
  assign redirect_tgt    = {redirect_addr_i[31:1], 1'b0};
  assign boot_branch     = (state_q == BOOT) & req_o & fetch_en_i;
  assign redirect_branch = fetch_en_i & redirect_i;
  assign branch_o        = boot_branch | redirect_branch;
  assign branch_spec_o   = branch_o;
  assign branch_addr_o   = redirect_branch ? redirect_tgt : branch_addr_q;

  // Ready never depends on valid_i.
  assign ready_o  = req_o & (state_q == RUN) & ~branch_o & ~fifo_full;
  assign accept   = valid_i & ready_o;
  assign fifo_pop = ~fifo_empty & instr_ready_i;

  assign push_entry.compressed = is_compressed(rdata_i);
  assign push_entry.rdata      = push_entry.compressed ? {16'h0000, rdata_i[15:0]} : rdata_i;
  assign push_entry.addr       = addr_i;
  assign push_entry.err        = err_i;
  assign push_entry.err_plus2  = err_plus2_i;

  ibex_icache_fetch_fifo #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .flush (redirect_branch),
    .push  (accept),
    .pop   (fifo_pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  // Head outputs are forced to zero while the FIFO is empty.
  assign instr_valid_o      = ~fifo_empty;
  assign instr_rdata_o      = fifo_empty ? 32'h0 : head.rdata;
  assign instr_addr_o       = fifo_empty ? 32'h0 : head.addr;
  assign instr_err_o        = ~fifo_empty & head.err;
  assign instr_err_plus2_o  = ~fifo_empty & head.err_plus2;
  assign instr_compressed_o = ~fifo_empty & head.compressed;

  // State register plus simple registered cache controls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= BOOT;
      branch_addr_q <= ResetPc;
      req_o         <= 1'b0;
      enable_o      <= 1'b0;
      invalidate_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_o        <= fetch_en_i;
      enable_o     <= icache_en_i;
      invalidate_o <= flush_i;
      if (redirect_branch) branch_addr_q <= redirect_tgt;
    end
  end

  // Next-state logic; a redirect always lands in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:     if (boot_branch) state_d = RUN;
      RUN:      if (accept && err_i) state_d = ERR_WAIT;
      ERR_WAIT: state_d = ERR_WAIT;
      default:  state_d = BOOT;
    endcase
    if (redirect_branch) state_d = RUN;
  end

`ifdef FETCH_SEQ_PC_CHECK_EN
  logic [31:0] exp_pc_q;
  logic        mismatch_q;

  // Expected-PC tracker with a sticky mismatch flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_pc_q   <= ResetPc;
      mismatch_q <= 1'b0;
    end else if (branch_o) begin
      exp_pc_q <= branch_addr_o;
    end else if (accept) begin
      exp_pc_q <= exp_pc_q + (push_entry.compressed ? 32'd2 : 32'd4);
      if (addr_i != exp_pc_q) mismatch_q <= 1'b1;
    end
  end

  assign pc_mismatch_o = mismatch_q;
`else
  assign pc_mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_icache_fetch_seq.sv
// Directed self-checking bench for ibex_icache_fetch_seq (FifoDepth = 2).
module tb_ibex_icache_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        fetch_en_i, redirect_i, icache_en_i, flush_i;
  logic [31:0] redirect_addr_i;
  logic        req_o, branch_o, branch_spec_o, ready_o, enable_o, invalidate_o;
  logic [31:0] branch_addr_o;
  logic        valid_i, err_i, err_plus2_i, busy_i, instr_ready_i;
  logic [31:0] rdata_i, addr_i;
  logic        instr_valid_o, instr_err_o, instr_err_plus2_o, instr_compressed_o;
  logic [31:0] instr_rdata_o, instr_addr_o;
  logic        pc_mismatch_o;

  int errors = 0;
  int checks = 0;
  logic exp_mismatch;

  always #5 clk = ~clk;

  ibex_icache_fetch_seq dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .fetch_en_i        (fetch_en_i),
    .redirect_i        (redirect_i),
    .redirect_addr_i   (redirect_addr_i),
    .icache_en_i       (icache_en_i),
    .flush_i           (flush_i),
    .req_o             (req_o),
    .branch_o          (branch_o),
    .branch_spec_o     (branch_spec_o),
    .branch_addr_o     (branch_addr_o),
    .ready_o           (ready_o),
    .enable_o          (enable_o),
    .invalidate_o      (invalidate_o),
    .valid_i           (valid_i),
    .rdata_i           (rdata_i),
    .addr_i            (addr_i),
    .err_i             (err_i),
    .err_plus2_i       (err_plus2_i),
    .busy_i            (busy_i),
    .instr_valid_o     (instr_valid_o),
    .instr_ready_i     (instr_ready_i),
    .instr_rdata_o     (instr_rdata_o),
    .instr_addr_o      (instr_addr_o),
    .instr_err_o       (instr_err_o),
    .instr_err_plus2_o (instr_err_plus2_o),
    .instr_compressed_o(instr_compressed_o),
    .pc_mismatch_o     (pc_mismatch_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs settle shortly after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic e);
    valid_i = 1'b1;
    addr_i  = a;
    rdata_i = d;
    err_i   = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef FETCH_SEQ_PC_CHECK_EN
    exp_mismatch = 1'b1;
`else
    exp_mismatch = 1'b0;
`endif
    rst_ni = 1'b0; fetch_en_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = '0;
    icache_en_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; rdata_i = '0; addr_i = '0;
    err_i = 1'b0; err_plus2_i = 1'b0; busy_i = 1'b0; instr_ready_i = 1'b0;

    // Reset state
    repeat (2) tick();
    #1;
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_branch", 32'(branch_o), 32'd0);
    chk("rst_baddr", branch_addr_o, 32'h80);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_ivalid", 32'(instr_valid_o), 32'd0);
    chk("rst_misc", 32'({enable_o, invalidate_o, pc_mismatch_o}), 32'd0);

    // Boot branch to ResetPc, then ready
    rst_ni = 1'b1; fetch_en_i = 1'b1; #1;
    chk("boot_nobranch_yet", 32'(branch_o), 32'd0);
    tick();
    chk("boot_branch", 32'(branch_o), 32'd1);
    chk("boot_spec", 32'(branch_spec_o), 32'd1);
    chk("boot_baddr", branch_addr_o, 32'h80);
    chk("boot_ready0", 32'(ready_o), 32'd0);
    tick();
    chk("run_branch0", 32'(branch_o), 32'd0);
    chk("run_ready", 32'(ready_o), 32'd1);

    // Two responses: 32-bit at 0x80, compressed at 0x84
    beat(32'h80, 32'h0000_0013, 1'b0);
    tick();
    beat(32'h84, 32'hABCD_0001, 1'b0); #1;
    chk("h0_valid", 32'(instr_valid_o), 32'd1);
    chk("h0_addr", instr_addr_o, 32'h80);
    chk("h0_comp", 32'(instr_compressed_o), 32'd0);
    chk("h0_rdata", instr_rdata_o, 32'h13);
    chk("h0_ready", 32'(ready_o), 32'd1);
    tick();

    // FIFO full: held beat at 0x86 not accepted, pop frees a slot
    beat(32'h86, 32'h1234_5673, 1'b0); instr_ready_i = 1'b1; #1;
    chk("full_ready0", 32'(ready_o), 32'd0);
    chk("full_head", instr_addr_o, 32'h80);
    tick();
    instr_ready_i = 1'b0; #1;
    chk("h1_addr", instr_addr_o, 32'h84);
    chk("h1_comp", 32'(instr_compressed_o), 32'd1);
    chk("h1_rdata", instr_rdata_o, 32'h0000_0001);
    chk("h1_ready", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0; instr_ready_i = 1'b1; #1;
    chk("full2_ready0", 32'(ready_o), 32'd0);
    tick();
    // Count 1: simultaneous push (0x8A) and pop (0x86)
    beat(32'h8A, 32'hFFFF_4102, 1'b0); #1;
    chk("h2_addr", instr_addr_o, 32'h86);
    chk("h2_rdata", instr_rdata_o, 32'h1234_5673);
    chk("pp_ready", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0; instr_ready_i = 1'b0; #1;
    chk("pp_head", instr_addr_o, 32'h8A);
    chk("pp_rdata", instr_rdata_o, 32'h0000_4102);
    chk("pp_notfull", 32'(ready_o), 32'd1);
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0; #1;
    chk("drained", 32'(instr_valid_o), 32'd0);

    // Redirect to 0x90, error beat, ERR_WAIT until redirect to 0x200
    redirect_i = 1'b1; redirect_addr_i = 32'h90; #1;
    chk("rd90_branch", 32'(branch_o), 32'd1);
    chk("rd90_baddr", branch_addr_o, 32'h90);
    chk("rd90_ready0", 32'(ready_o), 32'd0);
    tick();
    redirect_i = 1'b0;
    beat(32'h90, 32'h0000_0013, 1'b1);
    tick();
    valid_i = 1'b0; err_i = 1'b0; #1;
    chk("err_head", instr_err_o, 32'd1);
    chk("err_addr", instr_addr_o, 32'h90);
    chk("errwait_ready0", 32'(ready_o), 32'd0);
    tick();
    chk("errwait_ready0b", 32'(ready_o), 32'd0);
    redirect_i = 1'b1; redirect_addr_i = 32'h200; #1;
    chk("rd200_branch", 32'(branch_o), 32'd1);
    chk("rd200_baddr", branch_addr_o, 32'h200);
    tick();
    redirect_i = 1'b0; #1;
    chk("rd200_ready", 32'(ready_o), 32'd1);
    chk("rd200_flushed", 32'(instr_valid_o), 32'd0);
    chk("rd200_baddr_hold", branch_addr_o, 32'h200);

    // Fill two entries, then redirect to 0x301 flushes them
    beat(32'h200, 32'h0000_0013, 1'b0);
    tick();
    beat(32'h204, 32'h0000_0013, 1'b0);
    tick();
    valid_i = 1'b0; #1;
    chk("fill_full", 32'(ready_o), 32'd0);
    redirect_i = 1'b1; redirect_addr_i = 32'h301; #1;
    chk("rd301_baddr", branch_addr_o, 32'h300);
    tick();
    redirect_i = 1'b0; #1;
    chk("rd301_empty", 32'(instr_valid_o), 32'd0);
    chk("no_mismatch_yet", 32'(pc_mismatch_o), 32'd0);

    // PC check: 0x100 then 0x106 (expected 0x104)
    redirect_i = 1'b1; redirect_addr_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    beat(32'h100, 32'h0000_0013, 1'b0);
    tick();
    chk("pc_ok", 32'(pc_mismatch_o), 32'd0);
    beat(32'h106, 32'h0000_0013, 1'b0);
    tick();
    valid_i = 1'b0; #1;
    chk("pc_mismatch", 32'(pc_mismatch_o), 32'(exp_mismatch));
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0; #1;
    chk("pc_sticky", 32'(pc_mismatch_o), 32'(exp_mismatch));

    // fetch_en falling: ready drops next cycle, FIFO retained
    fetch_en_i = 1'b0; #1;
    chk("fen_ready_still", 32'(ready_o), 32'd1);
    tick();
    chk("fen_ready0", 32'(ready_o), 32'd0);
    chk("fen_req0", 32'(req_o), 32'd0);
    chk("fen_retain", instr_addr_o, 32'h106);

    // Flush pulse -> invalidate one cycle later, for one cycle
    flush_i = 1'b1; #1;
    chk("inv_pre", 32'(invalidate_o), 32'd0);
    tick();
    flush_i = 1'b0; #1;
    chk("inv_pulse", 32'(invalidate_o), 32'd1);
    tick();
    chk("inv_post", 32'(invalidate_o), 32'd0);

    // enable follows icache_en registered
    icache_en_i = 1'b1; #1;
    chk("en_pre", 32'(enable_o), 32'd0);
    tick();
    chk("en_set", 32'(enable_o), 32'd1);

    // Reset mid-RUN
    fetch_en_i = 1'b1;
    tick();
    chk("prerst_req", 32'(req_o), 32'd1);
    rst_ni = 1'b0; #1;
    chk("mrst_req", 32'(req_o), 32'd0);
    chk("mrst_enable", 32'(enable_o), 32'd0);
    chk("mrst_ivalid", 32'(instr_valid_o), 32'd0);
    chk("mrst_branch", 32'(branch_o), 32'd0);
    chk("mrst_mismatch", 32'(pc_mismatch_o), 32'd0);
    chk("mrst_baddr", branch_addr_o, 32'h80);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("reboot_branch", 32'(branch_o), 32'd1);
    chk("reboot_baddr", branch_addr_o, 32'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
